// File: rtl/fpu_fir_issue.sv
// Operand-issue sequencer for the floating-point FIR datapath.
// Keeps a TAPS-deep sample delay line and a TAPS-entry coefficient bank, and
// for every accepted sample streams TAPS (x[k], c[k]) pairs to the multiplier.
module fpu_fir_issue #(
    parameter bit          double = 1'b0,
    parameter int unsigned TAPS   = 8,
    localparam int unsigned W     = double ? 64 : 32,
    localparam int unsigned AW    = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_data,
    output logic          coef_busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          mul_valid,
    input  logic          mul_ready,
    output logic [W-1:0]  mul_a,
    output logic [W-1:0]  mul_b,
    output logic [AW-1:0] mul_tap,
    output logic          mul_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);
    localparam logic [AW-1:0] TAP_PREV = AW'(TAPS - 2);

    state_t          state;
    logic [AW-1:0]   tap;
    logic [W-1:0]    x [TAPS];
    logic [W-1:0]    c [TAPS];

    // Coefficient writes are only honoured between bursts and inside the bank.
    logic coef_wr_ok;
    assign coef_wr_ok = coef_we && (32'(coef_addr) < TAPS);

    // Sequencer, delay line, coefficient bank and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap       <= '0;
            mul_valid <= 1'b0;
            mul_last  <= 1'b0;
            coef_busy <= 1'b0;
            for (int k = 0; k < int'(TAPS); k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (coef_wr_ok) begin
                        c[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        x[0] <= in_data;
                        for (int k = 1; k < int'(TAPS); k++) begin
                            x[k] <= x[k-1];
                        end
                        tap       <= '0;
                        state     <= ISSUE;
                        mul_valid <= 1'b1;
                        coef_busy <= 1'b1;
                        mul_last  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (mul_ready) begin
                        if (tap == TAP_LAST) begin
                            state     <= IDLE;
                            tap       <= '0;
                            mul_valid <= 1'b0;
                            coef_busy <= 1'b0;
                            mul_last  <= 1'b0;
                        end else begin
                            tap      <= tap + AW'(1);
                            mul_last <= (tap == TAP_PREV);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand select straight from the tap counter; no path from mul_ready.
    assign mul_a   = x[tap];
    assign mul_b   = c[tap];
    assign mul_tap = tap;

    // Sample acceptance depends only on state and reset.
    assign in_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_fpu_fir_issue.sv
// Scoreboard bench for fpu_fir_issue (single precision, 8 taps).
module tb_fpu_fir_issue;

    localparam int unsigned N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [31:0] coef_data;
    logic        coef_busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        mul_valid;
    logic        mul_ready;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [2:0]  mul_tap;
    logic        mul_last;

    fpu_fir_issue #(.double(1'b0), .TAPS(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_busy (coef_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_tap   (mul_tap),
        .mul_last  (mul_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  tap;
        logic        last;
    } pair_t;

    pair_t       q[$];
    logic [31:0] xs [N];
    logic [31:0] cs [N];
    int          total = 0;
    int          bad = 0;
    bit          rand_ready = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a reset empties both the delay line and the bank.
    function automatic void model_reset();
        for (int k = 0; k < int'(N); k++) begin
            xs[k] = '0;
            cs[k] = '0;
        end
        q.delete();
    endfunction

    // Reference model: a new sample enters, and one burst of pairs is expected.
    function automatic void model_accept(input logic [31:0] s);
        for (int k = int'(N) - 1; k > 0; k--) xs[k] = xs[k-1];
        xs[0] = s;
        for (int k = 0; k < int'(N); k++) q.push_back('{xs[k], cs[k], 3'(k), (k == int'(N) - 1)});
    endfunction

    // Monitor: pops an expected pair on every handshake, checks stall stability.
    bit          held = 1'b0;
    logic [31:0] h_a, h_b;
    logic [2:0]  h_tap;
    logic        h_last;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (mul_valid) begin
            chk("busy_in_issue", 64'(coef_busy), 64'd1);
            if (held) begin
                chk("hold_stable", {mul_a, mul_b[27:0], mul_tap, mul_last},
                                   {h_a, h_b[27:0], h_tap, h_last});
            end
            if (mul_ready) begin
                held = 1'b0;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pair tap=%0d a=%h", mul_tap, mul_a);
                end else begin
                    pair_t e;
                    e = q.pop_front();
                    chk($sformatf("mul_a_tap%0d", e.tap), 64'(mul_a), 64'(e.a));
                    chk($sformatf("mul_b_tap%0d", e.tap), 64'(mul_b), 64'(e.b));
                    chk("tap_last", {60'd0, mul_tap, mul_last}, {60'd0, e.tap, e.last});
                end
            end else begin
                held   = 1'b1;
                h_a    = mul_a;
                h_b    = mul_b;
                h_tap  = mul_tap;
                h_last = mul_last;
            end
        end else begin
            held = 1'b0;
        end
    end

    // Random backpressure when enabled.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            mul_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic push(input logic [31:0] s, input bit wr, input logic [2:0] wa, input logic [31:0] wd);
        wait_in_ready();
        in_valid  = 1'b1;
        in_data   = s;
        coef_we   = wr;
        coef_addr = wa;
        coef_data = wd;
        @(posedge clk);
        if (wr) cs[wa] = wd;
        model_accept(s);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic wr_coef(input logic [2:0] wa, input logic [31:0] wd);
        bit idle;
        idle      = in_ready;
        coef_we   = 1'b1;
        coef_addr = wa;
        coef_data = wd;
        @(posedge clk);
        if (idle) cs[wa] = wd;
        #1;
        coef_we = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic load_ramp();
        logic [31:0] ramp [N];
        ramp = '{32'h0, 32'h3F800000, 32'h40000000, 32'h40400000,
                 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
        for (int k = 0; k < int'(N); k++) wr_coef(3'(k), ramp[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nvalid, n;
        bit [3:0] pat;
        rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        in_valid = 1'b0; in_data = '0; mul_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        chk("mul_valid_in_reset", 64'(mul_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_mul_valid", 64'(mul_valid), 64'd0);
        chk("reset_coef_busy", 64'(coef_busy), 64'd0);
        chk("reset_mul_last", 64'(mul_last), 64'd0);

        // Default coefficients: one sample, zero coefficients.
        push(32'h3F800000, 1'b0, '0, '0);
        wait_drain();

        // Ramp coefficients, three samples, latency and length of the last burst.
        load_ramp();
        push(32'h3F800000, 1'b0, '0, '0);
        wait_drain();
        push(32'h40000000, 1'b0, '0, '0);
        wait_drain();
        push(32'h40400000, 1'b0, '0, '0);
        cyc = 1; nvalid = 0;
        while (!in_ready && cyc < 50) begin
            if (mul_valid) nvalid++;
            @(posedge clk); #1; cyc++;
        end
        chk("burst_valid_cycles", 64'(nvalid), 64'(N));
        chk("in_ready_return_cycle", 64'(cyc), 64'(N + 1));
        chk("idle_coef_busy", 64'(coef_busy), 64'd0);

        // Backpressure pattern 1,0,0,1 starting at tap 0.
        push(32'h40800000, 1'b0, '0, '0);
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            mul_ready = pat[i];
            @(posedge clk); #1;
        end
        mul_ready = 1'b1;
        wait_drain();

        // Coefficient write during a burst is dropped.
        push(32'h40A00000, 1'b0, '0, '0);
        chk("busy_during_write", 64'(coef_busy), 64'd1);
        wr_coef(3'd3, 32'h12345678);
        wait_drain();
        push(32'h40C00000, 1'b0, '0, '0);
        wait_drain();

        // Reset at tap 4 aborts the burst and clears the delay line.
        push(32'h40E00000, 1'b0, '0, '0);
        n = 0;
        while (!(mul_valid && mul_tap == 3'd4) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("reached_tap4", 64'(mul_tap), 64'd4);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("abort_mul_valid", 64'(mul_valid), 64'd0);
        chk("abort_mul_last", 64'(mul_last), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        push(32'h40490FDB, 1'b0, '0, '0);
        wait_drain();

        // Write and accept in the same IDLE cycle.
        load_ramp();
        push(32'h3F800000, 1'b1, 3'd0, 32'h7FC00000);
        wait_drain();
        push(32'h41000000, 1'b1, 3'd7, 32'hFF800000);
        wait_drain();

        // Random samples, coefficient writes and backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) wr_coef(3'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 3) == 0)
                push($urandom, 1'b1, 3'($urandom_range(0, 7)), $urandom);
            else
                push($urandom, 1'b0, '0, '0);
        end
        wait_drain();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        mul_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
